// File: rtl/freq_peak_scheduler.sv
// freq_peak_scheduler: captures a 16-bin FFT frame and scans it one bin per cycle
// through a shared magnitude unit, reporting the strongest bin above THRESH.
module freq_peak_scheduler #(
    parameter logic [31:0] THRESH = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        ready,
    output logic        done,
    output logic [3:0]  freq,
    output logic [31:0] peak_mag,
    output logic        no_peak,
    output logic        overrun,
    output logic [7:0]  frame_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t             state_q;
    logic [31:0]        bank_q [16];
    logic [31:0]        din [16];
    logic [3:0]         scan_q, win_q, win_d, freq_q;
    logic [31:0]        max_q, max_d, peak_q, mag, re_sq, im_sq;
    logic signed [31:0] re, im;
    logic               upd, done_q, no_peak_q, overrun_q;
    logic [7:0]         cnt_q;
    assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
    // Squares of 16-bit values fit 2^30 each, so the unsigned 32-bit sum cannot overflow.
    always_comb begin
        re    = {{16{bank_q[scan_q][31]}}, bank_q[scan_q][31:16]};
        im    = {{16{bank_q[scan_q][15]}}, bank_q[scan_q][15:0]};
        re_sq = re * re;
        im_sq = im * im;
        mag   = re_sq + im_sq;
        upd   = mag > max_q && mag > THRESH;
        max_d = upd ? mag : max_q;
        win_d = upd ? scan_q : win_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            scan_q    <= '0;
            win_q     <= '0;
            max_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            freq_q    <= '0;
            peak_q    <= '0;
            no_peak_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= fft_valid && state_q == SCAN;
            case (state_q)
                IDLE, DONE: begin
                    if (fft_valid) begin
                        bank_q  <= din;
                        max_q   <= '0;
                        win_q   <= '0;
                        scan_q  <= '0;
                        state_q <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    max_q  <= max_d;
                    win_q  <= win_d;
                    scan_q <= scan_q + 4'd1;
                    if (scan_q == 4'd15) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        freq_q    <= win_d;
                        peak_q    <= max_d;
                        no_peak_q <= max_d == '0;
                        cnt_q     <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ready     = state_q != SCAN;
    assign done      = done_q;
    assign freq      = freq_q;
    assign peak_mag  = peak_q;
    assign no_peak   = no_peak_q;
    assign overrun   = overrun_q;
    assign frame_cnt = cnt_q;
endmodule

// File: doc/freq_peak_scheduler.md
FREQ_PEAK_SCHEDULER -- requirements
Module: freq_peak_scheduler

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter THRESH, default 0, as a 32-bit unsigned floor; a bin qualifies only if its magnitude is strictly greater than THRESH.

Ports (name  direction  width  meaning):
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fft_valid  in  1  frame strobe; fft_d0..fft_d15 are valid while high.
- fft_d0..fft_d15  in  32 each  signed bins; re = [31:16], im = [15:0], both two's complement.
- ready  out  1  frame can be accepted this cycle.
- done  out  1  one-cycle result pulse.
- freq  out  4  index of the peak bin.
- peak_mag  out  32  unsigned re^2 + im^2 of the peak bin.
- no_peak  out  1  no bin exceeded THRESH.
- overrun  out  1  one-cycle pulse: a frame was dropped.
- frame_cnt  out  8  count of completed frames.

REQ-003 One clock (clk); reset is synchronous and active-high (rst).

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-005 ready SHALL be 1 in IDLE and in DONE, and 0 in SCAN.
REQ-006 Frame acceptance SHALL occur at a rising edge where fft_valid=1 and ready=1, and SHALL:
- capture all 16 bins into an internal register bank;
- clear the running max and the index register;
- set the scan index to 0;
- go to SCAN.
REQ-007 SCAN SHALL process exactly one captured bin per cycle, in index order 0..15, through one shared magnitude unit (two 16x16 signed multipliers plus an adder).
REQ-008 Magnitude SHALL be re*re + im*im, computed unsigned at 32 bits. -32768 squared = 2^30; the worst-case sum 2^31 SHALL NOT overflow.
REQ-009 A bin SHALL replace the running max only if mag > running max and mag > THRESH. Ties therefore keep the lowest index.
REQ-010 At the edge that processes index 15, the FSM SHALL go to DONE and register the results:
- freq = winning index;
- peak_mag = winning magnitude;
- no_peak = 1 if no bin qualified, in which case freq = 0 and peak_mag = 0.
REQ-011 done SHALL be 1 for exactly the one cycle spent in DONE. If acceptance is at edge k, done is high from edge k+16 to edge k+17 (latency 16 cycles).
REQ-012 freq, peak_mag and no_peak SHALL hold their values until the next DONE entry or reset.
REQ-013 frame_cnt SHALL increment on DONE entry and wrap from 255 to 0.
REQ-014 DONE exit SHALL be:
- to SCAN if fft_valid=1 (back-to-back frame accepted at that edge);
- otherwise to IDLE.
REQ-015 fft_valid=1 while in SCAN SHALL be ignored. overrun SHALL pulse high for the following cycle, once per such cycle, and the captured data SHALL be unaffected.
REQ-016 Input bins SHALL be sampled only at acceptance. Changes to fft_d* during SCAN SHALL NOT affect the result.
REQ-017 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-018 rst=1 at a rising edge SHALL force all of the following in any state, including mid-SCAN:
- state = IDLE;
- done = 0, overrun = 0;
- freq = 0, peak_mag = 0, no_peak = 0;
- frame_cnt = 0;
- scan index and running max cleared.
REQ-019 A frame interrupted by reset SHALL produce no done pulse.
REQ-020 rst SHALL take priority over fft_valid in the same cycle.

Verification
REQ-021 Single peak: bin 5 = {re=300, im=-400}, all others {1,1}, THRESH=0 -> done exactly 16 cycles after acceptance; freq=5, peak_mag=250000, no_peak=0, frame_cnt=1.
REQ-022 Tie and extreme value: bins 3 and 9 = {-32768, -32768}, others 0 -> freq=3, peak_mag=0x80000000.
REQ-023 Threshold: THRESH=1000, all bins {10, 10} (mag 200) -> no_peak=1, freq=0, peak_mag=0, done still pulses.
REQ-024 Back-to-back and overrun:
- fft_valid held high continuously -> done every 17 cycles;
- an fft_valid pulse mid-SCAN -> overrun pulses 1 cycle and the result is unchanged;
- 256 frames -> frame_cnt wraps to 0.
REQ-025 Reset mid-SCAN: rst at scan index 7 -> no done pulse, all outputs 0, ready=1 the next cycle; a new frame then completes normally.
